fifo_get_unpacker: RTL and testbench
====================================

Name: fifo_get_unpacker

Overview:
Get-side consumer of the mixed-clock FIFO, running entirely in the clk_get domain. It pops 32-bit packed stereo words (two 16-bit samples) from FIFO_module and presents them downstream as a serial stream of 16-bit samples on a valid/ready handshake. It also keeps a popped-word counter and a sticky underrun flag for stream-health monitoring.

Parameters:
WORD_W, 32, FIFO word width; must equal 2*SAMPLE_W.
SAMPLE_W, 16, output sample width.
CNT_W, 16, width of the popped-word counter.

Ports:
clk_get  in  1  FIFO read-side clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset, sampled on rising clk_get.
empty_out  in  1  FIFO empty flag.
data_get  in  WORD_W  FIFO read data; valid in the cycle after a pop.
req_get  out  1  FIFO pop request.
sample_out  out  SAMPLE_W  current sample.
sample_valid  out  1  sample_out holds a valid sample.
sample_ready  in  1  downstream accepts the sample.
sample_ch  out  1  0 = low half (left), 1 = high half (right).
word_count  out  CNT_W  number of words popped since reset; wraps modulo 2^CNT_W.
underrun  out  1  sticky underrun flag.

Behaviour:
- Reset (reset=1 at an edge): req_get=0, sample_valid=0, sample_out=0, sample_ch=0, word_count=0, underrun=0. Internal state is cleared: halves=0, inflight=0, started=0.
- A pop occurs at an edge where req_get=1 and empty_out=0. FIFO latency: data_get is valid for the whole following cycle and is captured at the next edge.
- Internal state:
  - word register.
  - halves (0..2): halves remaining.
  - inflight: a pop was issued last edge.
  - started: first word has been captured.
- req_get is combinational: ~reset & ~empty_out & ~inflight & (halves==0 | (halves==1 & sample_ready)).
- Pop edge: inflight<=1; word_count<=word_count+1.
- Capture edge (inflight=1):
  - word<=data_get; halves<=2; inflight<=0; started<=1.
  - Any acceptance at this edge is impossible by construction, because halves==0 in that cycle.
- Outputs:
  - sample_valid = (halves!=0).
  - sample_out = word[SAMPLE_W-1:0] when halves==2, word[WORD_W-1:SAMPLE_W] when halves==1.
  - sample_ch = (halves==1).
- Accept edge (sample_valid & sample_ready): halves<=halves-1.
- Order is always low half then high half.
- Throughput: best case 2 samples per 3 clk_get cycles (one bubble cycle per word for FIFO latency).
- Underrun: set at any edge where started=1, sample_ready=1, sample_valid=0, inflight=0 and empty_out=1. It stays set until reset; the bubble cycle during a normal fetch is excluded.
- Downstream stall: a sample is held stable (sample_out, sample_ch unchanged) while sample_valid=1 and sample_ready=0. No further pop occurs while halves==2, or while halves==1 without ready.
- FIFO empty: req_get stays low; the unpacker drains its held halves, then sample_valid=0.
- Reset mid-operation: a word popped but not yet captured is discarded; it is lost from the stream and this is accepted. A reset on the capture edge takes priority over the capture.
- word_count at 2^CNT_W-1 wraps to 0 on the next pop.

Optional Feature:
FIFO_UNPACK_CSUM_EN
- Defined: adds output csum_out [WORD_W-1:0], reset to 0. On each capture edge, csum_out <= csum_out ^ data_get. Used to compare against the producer-side XOR of the input file.
- Undefined: port absent, no checksum register, no other behavioural change.

Test Plan:
- FIFO preloaded with 0x0002_0001, 0x0004_0003; sample_ready=1 → sample_out sequence 0x0001(ch0), 0x0002(ch1), bubble, 0x0003(ch0), 0x0004(ch1); word_count=2; underrun=0.
- Hold sample_ready=0 for 5 cycles with word 0xBEEF_CAFE loaded → sample_out=0xCAFE, sample_ch=0 stable, req_get=0 throughout; release → 0xCAFE then 0xBEEF.
- Drain FIFO with sample_ready=1 and empty_out=1 afterwards → underrun=1 one edge after the last high half is accepted; stays 1 after refill; cleared only by reset.
- Assert reset on the cycle after a pop of 0x1111_2222 → word never appears, sample_valid=0, word_count=0. Next word 0x3333_4444 → 0x4444 output first.
- Preset via 65535 pops (CNT_W=16) → word_count=0xFFFF; next pop → 0x0000.
- CSUM_EN, words 0xFFFF_0000 then 0x0F0F_F0F0 → csum_out=0xF0F0_F0F0; reset → 0.

Source files
------------

// File: rtl/fifo_get_unpacker_if.sv
// fifo_get_unpacker_if: FIFO read port plus the serial sample stream.
// master = the unpacker (pops the FIFO, drives samples);
// slave  = the FIFO/downstream side (supplies words, accepts samples).
interface fifo_get_unpacker_if #(
   parameter int WORD_W   = 32,
   parameter int SAMPLE_W = 16
);
   logic                empty_out;
   logic [WORD_W-1:0]   data_get;
   logic                req_get;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                sample_ready;
   logic                sample_ch;

   modport master (
      input  empty_out, data_get, sample_ready,
      output req_get, sample_out, sample_valid, sample_ch
   );

   modport slave (
      output empty_out, data_get, sample_ready,
      input  req_get, sample_out, sample_valid, sample_ch
   );
endinterface

// File: rtl/fifo_get_unpacker.sv
// fifo_get_unpacker: pops 32-bit packed stereo words from the FIFO read port
// and emits them as 16-bit samples, low half (left) first, then high half.
// Keeps a wrapping popped-word counter and a sticky underrun flag.
// Optional macro FIFO_UNPACK_CSUM_EN adds csum_out, the running XOR of every
// captured word.
module fifo_get_unpacker #(
   parameter int WORD_W   = 32,
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 16
) (
   input  logic                 clk_get,
   input  logic                 reset,
   fifo_get_unpacker_if.master  bus,
   output logic [CNT_W-1:0]     word_count,
   output logic                 underrun
`ifdef FIFO_UNPACK_CSUM_EN
   ,
   output logic [WORD_W-1:0]    csum_out
`else
`endif
);

   // Number of halves of the current word still to be presented.
   localparam logic [1:0] HALVES_NONE = 2'd0;
   localparam logic [1:0] HALVES_HIGH = 2'd1;
   localparam logic [1:0] HALVES_BOTH = 2'd2;

   logic [1:0]        halves;
   logic              inflight;   // a pop was issued at the previous edge
   logic              started;    // at least one word has been captured
   logic [WORD_W-1:0] word;
   logic              pop;
   logic              accept;

   // Pop request and sample presentation decoded from the held state.
   always_comb begin
      bus.req_get = ~reset & ~bus.empty_out & ~inflight &
                    ((halves == HALVES_NONE) |
                     ((halves == HALVES_HIGH) & bus.sample_ready));
      bus.sample_valid = (halves != HALVES_NONE);
      bus.sample_ch    = (halves == HALVES_HIGH);
      // NOTE: the default arm assigns sample_out on every path, so no latch is inferred.
      case (halves)
         HALVES_BOTH: bus.sample_out = word[SAMPLE_W-1:0];
         HALVES_HIGH: bus.sample_out = word[WORD_W-1:SAMPLE_W];
         default:     bus.sample_out = '0;
      endcase
   end

   assign pop    = bus.req_get;
   assign accept = bus.sample_valid & bus.sample_ready;

   // Control state, counter and health flag; reset wins over capture.
   always_ff @(posedge clk_get) begin
      if (reset) begin
         halves     <= HALVES_NONE;
         inflight   <= 1'b0;
         started    <= 1'b0;
         word_count <= '0;
         underrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch reads pre-edge values.
         if (pop) begin
            inflight   <= 1'b1;
            word_count <= word_count + CNT_W'(1);
         end
         if (inflight) begin
            // halves is NONE in the capture cycle, so no accept can coincide.
            halves   <= HALVES_BOTH;
            inflight <= 1'b0;
            started  <= 1'b1;
         end else if (accept) begin
            halves <= halves - 2'd1;
         end
         // The fetch bubble is excluded through inflight.
         if (started & bus.sample_ready & ~bus.sample_valid & ~inflight &
             bus.empty_out) begin
            underrun <= 1'b1;
         end
      end
   end

   // Word holding register, loaded one edge after each pop.
   // NOTE: not reset on purpose; sample_out is forced to 0 whenever halves is NONE.
   always_ff @(posedge clk_get) begin
      if (inflight) begin
         word <= bus.data_get;
      end
   end

`ifdef FIFO_UNPACK_CSUM_EN
   // Running XOR of captured words, comparable with the producer-side XOR.
   always_ff @(posedge clk_get) begin
      if (reset) begin
         csum_out <= '0;
      end else if (inflight) begin
         csum_out <= csum_out ^ bus.data_get;
      end
   end
`else
`endif

endmodule

// File: tb/tb_fifo_get_unpacker.sv
// tb_fifo_get_unpacker: directed bench for fifo_get_unpacker.
// A queue stands in for the FIFO: a pop seen at an edge puts the word on
// data_get for the whole following cycle. The counter wrap is exercised on a
// second instance built with CNT_W=3, fed by an always-non-empty FIFO.
// Honours FIFO_UNPACK_CSUM_EN to hook up and check csum_out.
module tb_fifo_get_unpacker;

   logic        clk_get = 1'b0;
   logic        reset;
   logic        reset2;
   logic [15:0] word_count;
   logic        underrun;
   logic [2:0]  word_count2;
   logic        underrun2;
`ifdef FIFO_UNPACK_CSUM_EN
   logic [31:0] csum_out;
   logic [31:0] csum_out2;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] fifo_q[$];

   always #5 clk_get = ~clk_get;

   fifo_get_unpacker_if #(.WORD_W(32), .SAMPLE_W(16)) bus ();
   fifo_get_unpacker_if #(.WORD_W(32), .SAMPLE_W(16)) bus2 ();

   fifo_get_unpacker #(.WORD_W(32), .SAMPLE_W(16), .CNT_W(16)) dut (
      .clk_get    (clk_get),
      .reset      (reset),
      .bus        (bus),
      .word_count (word_count),
      .underrun   (underrun)
`ifdef FIFO_UNPACK_CSUM_EN
      ,
      .csum_out   (csum_out)
`endif
   );

   fifo_get_unpacker #(.WORD_W(32), .SAMPLE_W(16), .CNT_W(3)) dut_wrap (
      .clk_get    (clk_get),
      .reset      (reset2),
      .bus        (bus2),
      .word_count (word_count2),
      .underrun   (underrun2)
`ifdef FIFO_UNPACK_CSUM_EN
      ,
      .csum_out   (csum_out2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
      bus.empty_out = 1'b0;
   endtask

   // One clock: sample the pop decision, let the edge pass, present FIFO
   // read data for the following cycle, return at the falling edge.
   task automatic tick();
      logic pop;
      #1;
      pop = bus.req_get & ~bus.empty_out;
      @(posedge clk_get);
      #1;
      if (pop && fifo_q.size() > 0) bus.data_get = fifo_q.pop_front();
      else                          bus.data_get = '0;
      bus.empty_out = (fifo_q.size() == 0);
      @(negedge clk_get);
   endtask

   initial begin
      reset            = 1'b1;
      reset2           = 1'b1;
      bus.empty_out    = 1'b1;
      bus.data_get     = '0;
      bus.sample_ready = 1'b0;
      bus2.empty_out    = 1'b0;
      bus2.data_get     = 32'hA5A5_5A5A;
      bus2.sample_ready = 1'b1;
      @(negedge clk_get);
      tick();
      tick();

      // Reset state
      chk("rst_req",      bus.req_get,      0);
      chk("rst_valid",    bus.sample_valid, 0);
      chk("rst_out",      bus.sample_out,   0);
      chk("rst_ch",       bus.sample_ch,    0);
      chk("rst_count",    word_count,       0);
      chk("rst_underrun", underrun,         0);

      // Two preloaded words, downstream always ready
      reset = 1'b0;
      push(32'h0002_0001);
      push(32'h0004_0003);
      bus.sample_ready = 1'b1;
      #1 chk("t1_req_first", bus.req_get, 1);
      tick();
      chk("t1_latency_valid", bus.sample_valid, 0);
      tick();
      chk("t1_s0_out",   bus.sample_out,   32'h0001);
      chk("t1_s0_ch",    bus.sample_ch,    0);
      chk("t1_s0_valid", bus.sample_valid, 1);
      tick();
      chk("t1_s1_out", bus.sample_out, 32'h0002);
      chk("t1_s1_ch",  bus.sample_ch,  1);
      chk("t1_s1_req", bus.req_get,    1);
      tick();
      chk("t1_bubble", bus.sample_valid, 0);
      tick();
      chk("t1_s2_out", bus.sample_out, 32'h0003);
      chk("t1_s2_ch",  bus.sample_ch,  0);
      tick();
      chk("t1_s3_out",    bus.sample_out, 32'h0004);
      chk("t1_s3_ch",     bus.sample_ch,  1);
      chk("t1_count",     word_count,     2);
      chk("t1_underrun",  underrun,       0);
      tick();
      chk("t3_drained_valid",    bus.sample_valid, 0);
      chk("t3_underrun_not_yet", underrun,         0);
      tick();
      chk("t3_underrun_set", underrun, 1);

      // Downstream stall on a loaded word, with more data waiting in the FIFO
      push(32'hBEEF_CAFE);
      push(32'h1234_5678);
      bus.sample_ready = 1'b0;
      tick();
      tick();
      chk("t2_first_out", bus.sample_out, 32'hCAFE);
      for (int i = 0; i < 5; i++) begin
         #1 chk("t2_stall_req", bus.req_get, 0);
         tick();
         chk("t2_stall_out",   bus.sample_out,   32'hCAFE);
         chk("t2_stall_ch",    bus.sample_ch,    0);
         chk("t2_stall_valid", bus.sample_valid, 1);
      end
      bus.sample_ready = 1'b1;
      #1 chk("t2_release_req", bus.req_get, 0);
      chk("t2_release_out", bus.sample_out, 32'hCAFE);
      tick();
      chk("t2_high_out", bus.sample_out, 32'hBEEF);
      chk("t2_high_ch",  bus.sample_ch,  1);
      chk("t2_high_req", bus.req_get,    1);
      tick();
      chk("t2_bubble", bus.sample_valid, 0);
      chk("t2_count",  word_count,       4);
      tick();
      chk("t2_next_lo", bus.sample_out, 32'h5678);
      tick();
      chk("t2_next_hi", bus.sample_out, 32'h1234);
      tick();
      chk("t3_sticky_after_refill", underrun, 1);

      // Reset one cycle after a pop discards the in-flight word
      reset = 1'b1;
      tick();
      chk("t4_underrun_cleared", underrun,   0);
      chk("t4_count_cleared",    word_count, 0);
      reset = 1'b0;
      push(32'h1111_2222);
      push(32'h3333_4444);
      tick();
      chk("t4_popped_count", word_count, 1);
      reset = 1'b1;
      tick();
      chk("t4_discard_valid", bus.sample_valid, 0);
      chk("t4_discard_count", word_count,       0);
      reset = 1'b0;
      tick();
      tick();
      chk("t4_next_lo",    bus.sample_out, 32'h4444);
      chk("t4_next_lo_ch", bus.sample_ch,  0);
      chk("t4_next_count", word_count,     1);
      tick();
      chk("t4_next_hi", bus.sample_out, 32'h3333);
      tick();

      // Checksum of two words, then reset
      reset = 1'b1;
      tick();
`ifdef FIFO_UNPACK_CSUM_EN
      chk("t6_csum_rst", csum_out, 0);
`endif
      reset = 1'b0;
      push(32'hFFFF_0000);
      push(32'h0F0F_F0F0);
      for (int i = 0; i < 7; i++) tick();
      chk("t6_count", word_count, 2);
`ifdef FIFO_UNPACK_CSUM_EN
      chk("t6_csum", csum_out, 32'hF0F0_F0F0);
`endif
      reset = 1'b1;
      tick();
`ifdef FIFO_UNPACK_CSUM_EN
      chk("t6_csum_after_reset", csum_out, 0);
`endif
      reset = 1'b0;

      // Counter wrap: a pop every 3 edges from edge 1, so edge 19 is pop 7
      reset2 = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      chk("t5_count_max", word_count2, 7);
      chk("t5_no_underrun", underrun2, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("t5_count_wrap", word_count2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
